fifo_ctrl: RTL and testbench

- Pointer and flag controller that turns the 2^N-entry register file into a first-word-fall-through FIFO.
- Sits directly upstream of the register file:
  - drives its write address, read address and write enable;
  - the register file's combinational read port supplies the head-of-queue data.
- Producer and consumer talk to this block through a wr/rd strobe interface with full/empty back-pressure.

---
 rtl/fifo_ctrl.sv | 79 +++++++
 tb/tb_fifo_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer and flag controller that turns a 2^ADDR_WIDTH-entry
// register file into a first-word-fall-through FIFO.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   wr, rd       push / pop requests for the current cycle
//   clr_err      synchronous clear of the sticky overflow / underflow flags
//   w_addr, we   register file write address and write enable
//   r_addr       register file read address, always the head entry
//   full, empty, almost_full, almost_empty, count   occupancy status
//   overflow, underflow                             sticky error flags
module fifo_ctrl #(
   parameter int ADDR_WIDTH = 7,
   parameter int AF_LEVEL   = 120,
   parameter int AE_LEVEL   = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr,
   input  logic                  rd,
   input  logic                  clr_err,
   output logic [ADDR_WIDTH-1:0] w_addr,
   output logic [ADDR_WIDTH-1:0] r_addr,
   output logic                  we,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0] AF_CNT  = (ADDR_WIDTH+1)'(AF_LEVEL);
   localparam logic [ADDR_WIDTH:0] AE_CNT  = (ADDR_WIDTH+1)'(AE_LEVEL);

   // MSB of each pointer is the wrap bit, which separates full from empty.
   logic [ADDR_WIDTH:0] w_ptr, r_ptr;
   logic                push_ok, pop_ok;

   assign w_addr = w_ptr[ADDR_WIDTH-1:0];
   assign r_addr = r_ptr[ADDR_WIDTH-1:0];

   assign empty = (w_ptr == r_ptr);
   assign full  = (w_ptr[ADDR_WIDTH] != r_ptr[ADDR_WIDTH]) &&
                  (w_ptr[ADDR_WIDTH-1:0] == r_ptr[ADDR_WIDTH-1:0]);
   assign count = w_ptr - r_ptr;

   assign almost_full  = (count >= AF_CNT);
   assign almost_empty = (count <= AE_CNT);

   // A write into a full FIFO is legal when a pop frees the head slot on the
   // same edge; the head value is read combinationally before it is replaced.
   assign pop_ok  = rd & ~empty;
   assign push_ok = wr & (~full | pop_ok);
   assign we      = push_ok;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w_ptr     <= '0;
         r_ptr     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (push_ok) w_ptr <= w_ptr + PTR_ONE;
         if (pop_ok)  r_ptr <= r_ptr + PTR_ONE;

         // A fresh error in the clearing cycle takes priority over clr_err.
         if (wr & full & ~pop_ok) overflow <= 1'b1;
         else if (clr_err)        overflow <= 1'b0;

         if (rd & empty)          underflow <= 1'b1;
         else if (clr_err)        underflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fifo_ctrl.sv
module tb_fifo_ctrl;

   localparam int AW    = 7;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          reset, wr, rd, clr_err;
   logic [AW-1:0] w_addr, r_addr;
   logic          we, full, empty, almost_full, almost_empty;
   logic [AW:0]   count;
   logic          overflow, underflow;

   // Register file model: registered write, combinational read.
   logic [7:0]    mem [DEPTH];
   logic [7:0]    data_w;
   logic [7:0]    data_r;

   int checks   = 0;
   int failures = 0;
   logic [7:0] exp_q[$];

   fifo_ctrl #(.ADDR_WIDTH(AW), .AF_LEVEL(120), .AE_LEVEL(8)) dut (
      .clk(clk), .reset(reset), .wr(wr), .rd(rd), .clr_err(clr_err),
      .w_addr(w_addr), .r_addr(r_addr), .we(we), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (we) mem[w_addr] <= data_w;
   assign data_r = mem[r_addr];

   task automatic test_reset();
      reset = 1'b1; wr = 0; rd = 0; clr_err = 0; data_w = 0;
      repeat (2) @(posedge clk);
      @(negedge clk); reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); wr = 1; data_w = 8'(i);
      end
      @(posedge clk); #3;
      reset = 1'b1;
      #1;
      checks++;
      if (count !== 0 || empty !== 1 || full !== 0 || almost_empty !== 1 ||
          almost_full !== 0 || overflow !== 0 || underflow !== 0 ||
          r_addr !== 0 || w_addr !== 0) begin
         failures++;
         $display("FAIL reset_state: count=%0d empty=%b full=%b ae=%b af=%b ov=%b un=%b ra=%0d wa=%0d, need 0 1 0 1 0 0 0 0 0",
                  count, empty, full, almost_empty, almost_full, overflow, underflow, r_addr, w_addr);
      end
      checks++;
      if (we !== 1'b1) begin
         failures++; $display("FAIL reset_we: we=%b need 1 (wr=1)", we);
      end
      @(negedge clk); wr = 0; reset = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_fill();
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk); wr = 1; rd = 0; data_w = 8'(i);
         #1;
         checks++;
         if (we !== 1 || w_addr !== AW'(i)) begin
            failures++; $display("FAIL fill_we_addr[%0d]: we=%b w_addr=%0d need 1 %0d", i, we, w_addr, i);
         end
         exp_q.push_back(data_w);
         @(posedge clk); #1;
         checks++;
         if (count !== (i+1) || almost_full !== (i+1 >= 120) || full !== (i+1 == DEPTH)) begin
            failures++;
            $display("FAIL fill_flags[%0d]: count=%0d af=%b full=%b need %0d %b %b",
                     i, count, almost_full, full, i+1, (i+1 >= 120), (i+1 == DEPTH));
         end
      end
      @(negedge clk); wr = 0;
   endtask

   task automatic test_overflow();
      @(negedge clk); wr = 1; rd = 0; data_w = 8'hEE;
      #1;
      checks++;
      if (we !== 0) begin failures++; $display("FAIL ovf_we: we=%b need 0", we); end
      @(posedge clk); #1;
      checks++;
      if (overflow !== 1 || count !== DEPTH || w_addr !== 0 || r_addr !== 0 || full !== 1) begin
         failures++;
         $display("FAIL ovf_state: ov=%b count=%0d wa=%0d ra=%0d full=%b need 1 128 0 0 1",
                  overflow, count, w_addr, r_addr, full);
      end
      @(negedge clk); wr = 0; clr_err = 1;
      @(posedge clk); #1;
      checks++;
      if (overflow !== 0) begin failures++; $display("FAIL ovf_clear: ov=%b need 0", overflow); end
      @(negedge clk); clr_err = 0;
   endtask

   task automatic test_back_to_back();
      logic [7:0] e;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk); wr = 1; rd = 1; data_w = 8'(200 + k);
         #1;
         e = exp_q.pop_front();
         exp_q.push_back(data_w);
         checks++;
         if (data_r !== e || we !== 1) begin
            failures++; $display("FAIL simul_data[%0d]: data_r=%0d we=%b need %0d 1", k, data_r, we, e);
         end
         @(posedge clk); #1;
         checks++;
         if (count !== DEPTH || full !== 1 || overflow !== 0) begin
            failures++;
            $display("FAIL simul_flags[%0d]: count=%0d full=%b ov=%b need 128 1 0", k, count, full, overflow);
         end
      end
      @(negedge clk); wr = 0; rd = 0;
   endtask

   task automatic test_drain();
      logic [7:0] e;
      logic [AW-1:0] ra;
      ra = 7'd10;
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk); wr = 0; rd = 1;
         #1;
         e = exp_q.pop_front();
         checks++;
         if (data_r !== e || r_addr !== ra) begin
            failures++; $display("FAIL drain_data[%0d]: data_r=%0d r_addr=%0d need %0d %0d", i, data_r, r_addr, e, ra);
         end
         ra = ra + 7'd1;
         @(posedge clk); #1;
         checks++;
         if (count !== (127 - i) || almost_empty !== ((127 - i) <= 8) || empty !== (i == DEPTH-1)) begin
            failures++;
            $display("FAIL drain_flags[%0d]: count=%0d ae=%b empty=%b need %0d %b %b",
                     i, count, almost_empty, empty, 127-i, ((127-i) <= 8), (i == DEPTH-1));
         end
      end
      // 129th pop on an empty FIFO
      @(negedge clk); rd = 1;
      @(posedge clk); #1;
      checks++;
      if (underflow !== 1 || r_addr !== 7'd10 || count !== 0 || empty !== 1) begin
         failures++;
         $display("FAIL underflow: un=%b r_addr=%0d count=%0d empty=%b need 1 10 0 1", underflow, r_addr, count, empty);
      end
      // clear coinciding with a new underflow: the error wins
      @(negedge clk); rd = 1; clr_err = 1;
      @(posedge clk); #1;
      checks++;
      if (underflow !== 1) begin failures++; $display("FAIL clr_vs_err: un=%b need 1", underflow); end
      @(negedge clk); rd = 0; clr_err = 1;
      @(posedge clk); #1;
      checks++;
      if (underflow !== 0) begin failures++; $display("FAIL un_clear: un=%b need 0", underflow); end
      @(negedge clk); clr_err = 0;
   endtask

   task automatic test_empty_simul();
      @(negedge clk); wr = 1; rd = 1; data_w = 8'h5A;
      #1;
      checks++;
      if (we !== 1) begin failures++; $display("FAIL esim_we: we=%b need 1", we); end
      @(posedge clk); #1;
      checks++;
      if (count !== 1 || underflow !== 1 || empty !== 0) begin
         failures++; $display("FAIL esim_state: count=%0d un=%b empty=%b need 1 1 0", count, underflow, empty);
      end
      @(negedge clk); wr = 0; rd = 1;
      #1;
      checks++;
      if (data_r !== 8'h5A) begin failures++; $display("FAIL esim_data: data_r=%0h need 5a", data_r); end
      @(posedge clk); #1;
      checks++;
      if (empty !== 1 || count !== 0) begin
         failures++; $display("FAIL esim_pop: empty=%b count=%0d need 1 0", empty, count);
      end
      @(negedge clk); rd = 0;
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
      test_reset();
      test_fill();
      test_overflow();
      test_back_to_back();
      test_drain();
      test_empty_simul();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
